ping_pong_drain: RTL and testbench
==================================

# ping_pong_drain

Downstream consumer for the ping-pong buffer's read port. It issues read strobes whenever a buffer is available and it has room. It captures the one-cycle-latency read data into a small FIFO and presents it as a valid/ready stream. Each word is tagged with its source buffer, and the last word of every block is marked. It also keeps a block counter and a sticky sequencing-error flag for the system status registers.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must match the ping-pong buffer.
- BLOCK_SIZE, 16, words per buffer block; must match the ping-pong buffer's BUFFER_SIZE.
- SKID_DEPTH, 4, output FIFO entries; power of 2, minimum 3 (required for full throughput).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- enable  in  1  when low, no new reads are issued; reads already in flight still complete.
- buf_read_en  out  1  read strobe to the ping-pong buffer.
- buf_read_data  in  DATA_WIDTH  registered read data; valid one cycle after an accepted strobe.
- buf_read_empty  in  1  registered empty flag from the ping-pong buffer.
- buf_read_buffer  in  1  index of the buffer currently being read.
- out_valid  out  1  stream word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_WIDTH  word at the FIFO head.
- out_last  out  1  head word is word BLOCK_SIZE-1 of its block.
- out_buf_id  out  1  source buffer of the head word.
- block_count  out  16  number of blocks fully emitted (last word accepted); wraps.
- seq_error  out  1  sticky; set when the source buffer changes in the middle of a block.

## Operation
- Read issue, combinational: buf_read_en = enable && !buf_read_empty && (fifo_count + inflight < SKID_DEPTH).
  - buf_read_en does not depend on out_ready.
- inflight: a register that is 1 in the cycle after any asserted buf_read_en.
- inflight_id: register that samples buf_read_buffer in the issue cycle.
- Capture: when inflight=1, push one entry {buf_read_data, last = (pos == BLOCK_SIZE-1), inflight_id} into the FIFO.
- pos counter (width clog2(BLOCK_SIZE)):
  - increments on each capture;
  - returns to 0 after BLOCK_SIZE-1.
- seq_error: set on a capture with pos != 0 whose id differs from the id of the previous capture. Cleared only by reset.
- Output:
  - out_valid = (fifo_count != 0);
  - out_data, out_last and out_buf_id come from the head entry;
  - a pop occurs on out_valid && out_ready.
- Push and pop in the same cycle leave fifo_count unchanged. The FIFO cannot overflow, because the issue gate reserves a slot for every in-flight read.
- block_count increments by 1 (mod 2^16) on each pop whose out_last=1.
- Dropping enable in the middle of a block is legal: pos is preserved and resumes when enable returns.

## Timing
- Reset (asynchronous on rst_n low; release is synchronous to clk):
  - buf_read_en=0, out_valid=0, out_data=0, out_last=0, out_buf_id=0;
  - block_count=0, seq_error=0;
  - pos=0, inflight=0, FIFO empty.
- A reset in the middle of a block discards in-flight and FIFO data. pos restarts at 0.
- Latency: buf_read_en high in cycle t → data captured at the end of t+1 → out_valid high in t+2.
- Throughput: 1 word/cycle sustained while out_ready=1 and buf_read_empty=0.
- Upstream empty: buf_read_empty is registered upstream, so the strobe in the cycle after a block's last read already sees the updated flag. No extra guard cycle is required.
- Backpressure:
  - out_valid, out_data, out_last and out_buf_id hold stable while out_valid && !out_ready;
  - buf_read_en deasserts once fifo_count + inflight reaches SKID_DEPTH.
- enable falling in cycle t: buf_read_en is low from cycle t. A read issued in t-1 is still captured.

## Test plan
- Single block: upstream fills buffer 0 with 0x00..0x0F, out_ready=1.
  - Expect 16 words 0x00..0x0F on consecutive cycles, first at strobe+2.
  - out_last only on 0x0F; out_buf_id=0; block_count=1.
- Back-to-back blocks: buffers 0 and 1 both full (0x00..0x1F).
  - Expect 32 words with no bubbles.
  - out_last on 0x0F and 0x1F; out_buf_id switches 0→1 at word 0x10; block_count=2.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly during one block.
  - Expect no loss or duplication and data stable while stalled.
  - fifo_count never exceeds SKID_DEPTH.
  - buf_read_en drops while full.
- Enable gating: deassert enable after 5 words and re-enable 10 cycles later.
  - Expect exactly 5 words (plus at most one in flight), then the remaining words.
  - out_last on the 16th word overall.
- Sequencing error: force buf_read_buffer to flip at pos=7.
  - Expect seq_error=1 after that capture; it stays 1 until rst_n.
- Async reset in the middle of a block:
  - assert rst_n=0 at pos=9 with a full FIFO; all outputs go to reset values immediately;
  - after release and a fresh block, the first word has pos 0 and block_count counts from 0.

Source files
------------

// File: rtl/ping_pong_drain.sv
// rtl/ping_pong_drain.sv - read-side drain of the ping-pong buffer: strobe issue, skid FIFO, block tagging
//
// ping_pong_drain_fifo : power-of-2 skid FIFO with occupancy count; head reads as 0 when empty.
// ping_pong_drain ports:
//   clk, rst_n                         clock, async active-low reset
//   enable                             gate for issuing new read strobes
//   buf_read_en/_data/_empty/_buffer   ping-pong buffer read port (data one cycle after strobe)
//   out_valid/out_ready/out_data       output stream
//   out_last, out_buf_id               head word is last of its block / source buffer of head word
//   block_count                        blocks whose last word was accepted (wraps)
//   seq_error                          sticky: source buffer changed mid-block

module ping_pong_drain_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

module ping_pong_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  buf_read_en,
  input  logic [DATA_WIDTH-1:0] buf_read_data,
  input  logic                  buf_read_empty,
  input  logic                  buf_read_buffer,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_buf_id,
  output logic [15:0]           block_count,
  output logic                  seq_error
);

  localparam int POS_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int CW    = $clog2(SKID_DEPTH) + 1;
  localparam int EW    = DATA_WIDTH + 2;

  logic             inflight_q, inflight_d;
  logic             inflight_id_q, inflight_id_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             prev_id_q, prev_id_d;
  logic             seq_error_q, seq_error_d;
  logic [15:0]      block_count_q, block_count_d;

  logic [CW-1:0]    fifo_count;
  logic [CW:0]      reserved;
  logic             pos_last;
  logic             pop;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head;

  // Every in-flight read already owns a FIFO slot, so the FIFO can never overflow.
  assign reserved    = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  // rst_n is folded in so the strobe is low for the whole reset, not just after the first edge.
  assign buf_read_en = rst_n && enable && !buf_read_empty && (reserved < (CW+1)'(SKID_DEPTH));

  assign pos_last   = (pos_q == POS_W'(BLOCK_SIZE - 1));
  assign push_entry = {pos_last, inflight_id_q, buf_read_data};

  assign pop        = out_valid && out_ready;

  ping_pong_drain_fifo #(
    .WIDTH (EW),
    .DEPTH (SKID_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign out_valid   = (fifo_count != '0);
  assign out_last    = head[EW-1];
  assign out_buf_id  = head[EW-2];
  assign out_data    = head[DATA_WIDTH-1:0];
  assign block_count = block_count_q;
  assign seq_error   = seq_error_q;

  always_comb begin
    inflight_d    = buf_read_en;
    inflight_id_d = buf_read_en ? buf_read_buffer : inflight_id_q;
    pos_d         = pos_q;
    prev_id_d     = prev_id_q;
    seq_error_d   = seq_error_q;
    block_count_d = block_count_q;
    if (inflight_q) begin
      pos_d     = pos_last ? '0 : pos_q + POS_W'(1);
      prev_id_d = inflight_id_q;
      // pos != 0 guarantees a previous capture in this block, so prev_id_q is meaningful.
      if ((pos_q != '0) && (inflight_id_q != prev_id_q)) seq_error_d = 1'b1;
    end
    if (pop && out_last) block_count_d = block_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
      pos_q         <= '0;
      prev_id_q     <= 1'b0;
      seq_error_q   <= 1'b0;
      block_count_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      pos_q         <= pos_d;
      prev_id_q     <= prev_id_d;
      seq_error_q   <= seq_error_d;
      block_count_q <= block_count_d;
    end
  end

endmodule

// File: tb/tb_ping_pong_drain.sv
// tb/tb_ping_pong_drain.sv - self-checking bench for ping_pong_drain
module tb_ping_pong_drain;

  localparam int DW = 8;
  localparam int BS = 16;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          buf_read_en;
  logic [DW-1:0] buf_read_data = '0;
  logic          buf_read_empty = 1'b1;
  logic          buf_read_buffer = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_buf_id;
  logic [15:0]   block_count;
  logic          seq_error;

  always #5 clk = ~clk;

  ping_pong_drain #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .SKID_DEPTH(SD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .buf_read_en     (buf_read_en),
    .buf_read_data   (buf_read_data),
    .buf_read_empty  (buf_read_empty),
    .buf_read_buffer (buf_read_buffer),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_buf_id      (out_buf_id),
    .block_count     (block_count),
    .seq_error       (seq_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Upstream source words {id, data} and expected stream {last, id, data}.
  logic [8:0] src_q[$];
  logic [9:0] exp_q[$];
  int         m_idx = 0;
  logic       m_prev_id = 1'b0;
  logic       m_seq = 1'b0;
  int         exp_blocks = 0;
  int         issued = 0;
  int         popped = 0;
  int         ready_mode = 0;
  int         target = 0;
  int         cyc = 0;

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    m_idx = 0;
    m_prev_id = 1'b0;
    m_seq = 1'b0;
    exp_blocks = 0;
    issued = 0;
    popped = 0;
  endtask

  // Ping-pong buffer read side: registered data and empty flag, one-cycle latency.
  initial begin : upstream
    logic       issue;
    logic [8:0] w;
    forever begin
      @(negedge clk);
      issue = buf_read_en;
      @(posedge clk);
      #1;
      if (issue && src_q.size() > 0) begin
        w = src_q.pop_front();
        buf_read_data = w[7:0];
        exp_q.push_back({((m_idx % BS) == BS - 1), w[8], w[7:0]});
        if ((m_idx % BS) != 0 && w[8] != m_prev_id) m_seq = 1'b1;
        m_prev_id = w[8];
        m_idx++;
        issued++;
      end
      buf_read_empty = (src_q.size() == 0);
      if (src_q.size() > 0) buf_read_buffer = src_q[0][8];
    end
  end

  // Stream monitor: ordering, tagging, stall stability, occupancy bound, bubbles.
  initial begin : monitor
    logic          prev_stall;
    logic [DW-1:0] s_data;
    logic          s_last, s_id;
    logic [9:0]    e;
    prev_stall = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    s_id = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, s_data);
          check("stall_last", out_last, s_last);
          check("stall_id", out_buf_id, s_id);
        end
        if (issued - popped > SD) check("occupancy", issued - popped, SD);
        if (ready_mode == 0 && popped > 0 && popped < target) check("no_bubble", out_valid, 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pop", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[7:0]);
            check("out_buf_id", out_buf_id, e[8]);
            check("out_last", out_last, e[9]);
            check("block_count_run", block_count, exp_blocks);
            if (e[9]) exp_blocks++;
          end
          popped++;
        end
        prev_stall = out_valid && !out_ready;
        s_data = out_data;
        s_last = out_last;
        s_id = out_buf_id;
      end
    end
  end

  task automatic check_reset_values(string tag);
    check({tag, "_en"}, buf_read_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_id"}, out_buf_id, 0);
    check({tag, "_blocks"}, block_count, 0);
    check({tag, "_seq"}, seq_error, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_values("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tick_ready();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
  endtask

  task automatic wait_drain(int n, int budget);
    int b;
    b = 0;
    while (popped < n && b < budget) begin
      tick_ready();
      b++;
    end
    @(negedge clk);
    check("drain_timeout", popped >= n, 1);
  endtask

  typedef struct {
    int          nwords;
    logic [7:0]  base;
    int          flip_at;
    int          ready_mode;
    logic [15:0] exp_blocks;
    logic        exp_seq;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    logic       id;
    logic [7:0] d;
    int         frozen;
    int         b;

    vecs[0] = '{16, 8'h00, -1, 0, 16'd1, 1'b0};  // single block, buffer 0
    vecs[1] = '{32, 8'h00, -1, 0, 16'd2, 1'b0};  // back-to-back blocks 0 then 1
    vecs[2] = '{16, 8'h40, -1, 1, 16'd1, 1'b0};  // ready 1,0,0,1
    vecs[3] = '{48, 8'h00, -1, 2, 16'd3, 1'b0};  // random data and ready
    vecs[4] = '{32, 8'h10,  7, 1, 16'd2, 1'b1};  // buffer flips at pos 7, sticky after

    for (int i = 0; i < 5; i++) begin
      enable = 1'b0;
      do_reset();
      ready_mode = vecs[i].ready_mode;
      target = vecs[i].nwords;
      enable = 1'b1;
      for (int k = 0; k < vecs[i].nwords; k++) begin
        id = (vecs[i].flip_at >= 0) ? (k >= vecs[i].flip_at) : (((k / BS) % 2) == 1);
        d = (vecs[i].ready_mode == 2) ? 8'($urandom) : 8'(vecs[i].base + 8'(k));
        src_q.push_back({id, d});
      end
      wait_drain(vecs[i].nwords, 3000);
      repeat (2) @(negedge clk);
      check("vec_blocks", block_count, vecs[i].exp_blocks);
      check("vec_seq", seq_error, vecs[i].exp_seq);
      check("vec_seq_model", seq_error, m_seq);
      check("vec_idle", out_valid, 0);
      check("vec_all_out", exp_q.size(), 0);
      target = 0;
    end

    // Latency and backpressure: strobe at t, valid at t+2, strobe drops at SD reserved.
    enable = 1'b0;
    out_ready = 1'b0;
    ready_mode = 1;
    do_reset();
    for (int k = 0; k < BS; k++) src_q.push_back({1'b0, 8'(8'h20 + 8'(k))});
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    @(negedge clk);
    check("lat_t0_en", buf_read_en, 1);
    check("lat_t0_valid", out_valid, 0);
    @(negedge clk);
    check("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_data", out_data, 8'h20);
    check("lat_t2_en", buf_read_en, 1);
    @(negedge clk);
    check("lat_t3_en", buf_read_en, 1);
    @(negedge clk);
    check("full_en", buf_read_en, 0);
    @(negedge clk);
    check("full_en_hold", buf_read_en, 0);
    check("full_issued", issued, SD);
    wait_drain(BS, 500);
    check("bp_blocks", block_count, 1);

    // Enable gating mid-block.
    do_reset();
    ready_mode = 0;
    out_ready = 1'b1;
    for (int k = 0; k < BS; k++) src_q.push_back({1'b1, 8'(8'h60 + 8'(k))});
    b = 0;
    while (issued < 5 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("gate_reach5", issued >= 5, 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    check("gate_en_low", buf_read_en, 0);
    frozen = issued;
    check("gate_at_most_one_more", (frozen >= 5) && (frozen <= 6), 1);
    repeat (10) @(negedge clk);
    check("gate_frozen", issued, frozen);
    check("gate_drained", popped, frozen);
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_drain(BS, 500);
    check("gate_blocks", block_count, 1);

    // Async reset mid-block with a full FIFO (block_count is 1 going in).
    out_ready = 1'b1;
    ready_mode = 0;
    for (int k = 0; k < BS; k++) src_q.push_back({1'b0, 8'(8'h80 + 8'(k))});
    b = 0;
    while (popped < BS + 5 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("mid_reach", popped >= BS + 5, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_full_valid", out_valid, 1);
    check("mid_full_en", buf_read_en, 0);
    check("mid_blocks_pre", block_count, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_values("mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < BS; k++) src_q.push_back({1'b1, 8'(8'hC0 + 8'(k))});
    wait_drain(BS, 500);
    repeat (2) @(negedge clk);
    check("post_blocks", block_count, 1);
    check("post_seq", seq_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
